// File: rtl/multicycle_adder_pkg.sv
// Shared types and helpers for the multi-cycle add/subtract unit.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder built from full_adder cells.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell; the building block of every ripple chain here.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract: one CHUNK-wide slice per clock with a registered
// inter-chunk carry. Accepts in IDLE only, presents the result in DONE.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends combinationally on ready on either side.

  localparam int NCHUNKS = WIDTH / CHUNK;
  localparam int CW      = (NCHUNKS > 1) ? clog2(NCHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNKS - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;
  logic             load, step, last;
  logic [31:0]      base;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign last = (cnt_q == LAST);
  assign base = {{(32-CW){1'b0}}, cnt_q} * 32'(CHUNK);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[base +: CHUNK]),
    .b    (b_q[base +: CHUNK]),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  // Subtraction is folded in at accept time: invert b and force carry-in.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= op_sub ? ~b : b;
      carry_q <= op_sub | cin;
      cnt_q   <= '0;
    end else if (step) begin
      sum_q[base +: CHUNK] <= ch_sum;
      carry_q              <= ch_cout;
      if (last) begin
        cnt_q  <= '0;
        cout_q <= ch_cout;
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ch_sum[CHUNK-1] != a_q[WIDTH-1]);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three instances (CHUNK 8, 32, 4) sharing one
// clock, a driver task per op, and a negedge monitor popping expected queues.
module tb_multicycle_adder;
  import multicycle_adder_pkg::*;

  localparam int W    = 32;
  localparam int EW   = W + 2;
  localparam int NCFG = 3;
  localparam int NCH [NCFG] = '{4, 1, 8};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid  [NCFG];
  logic         in_ready  [NCFG];
  logic [W-1:0] a         [NCFG];
  logic [W-1:0] b         [NCFG];
  logic         cin       [NCFG];
  logic         op_sub    [NCFG];
  logic         out_valid [NCFG];
  logic         out_ready [NCFG];
  logic [W-1:0] sum       [NCFG];
  logic         cout      [NCFG];
  logic         ovf       [NCFG];
  state_t       dbg_state [NCFG];

  multicycle_adder #(.WIDTH(W), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .op_sub(op_sub[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum[0]),
    .cout(cout[0]), .ovf(ovf[0]), .dbg_state(dbg_state[0])
  );

  multicycle_adder #(.WIDTH(W), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .op_sub(op_sub[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum[1]),
    .cout(cout[1]), .ovf(ovf[1]), .dbg_state(dbg_state[1])
  );

  multicycle_adder #(.WIDTH(W), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .op_sub(op_sub[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum[2]),
    .cout(cout[2]), .ovf(ovf[2]), .dbg_state(dbg_state[2])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  task automatic push_exp(input int k, input logic [EW-1:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [EW-1:0] q_pop(input int k);
    case (k)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  // Full-width reference, used only for the random ops.
  function automatic logic [EW-1:0] ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                              input logic c, input logic s);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         o;
    be   = s ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : c)};
    o    = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
    return {o, full[W], full[W-1:0]};
  endfunction

  // Monitor: a result transfers on the edge after a negedge where valid && ready.
  always @(negedge clk) begin
    for (int k = 0; k < NCFG; k++) begin
      if (!rst && out_valid[k] && out_ready[k]) begin
        if (q_size(k) == 0) fail_now($sformatf("unexpected_result_cfg%0d", k));
        else check($sformatf("result_cfg%0d", k), {ovf[k], cout[k], sum[k]}, q_pop(k));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c, input logic s, input logic [EW-1:0] ev,
                       input bit do_push, output int acc);
    int waited;
    waited      = 0;
    a[k]        = av;
    b[k]        = bv;
    cin[k]      = c;
    op_sub[k]   = s;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[k]) begin
      fail_now($sformatf("accept_timeout_cfg%0d", k));
      in_valid[k] = 1'b0;
      acc = -1;
      return;
    end
    if (do_push) push_exp(k, ev);
    acc = ncyc;
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int waited;
    waited = 0;
    while (!out_valid[k] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid[k]) fail_now($sformatf("valid_timeout_cfg%0d", k));
  endtask

  task automatic wait_idle(input int k);
    int waited;
    waited = 0;
    while ((q_size(k) != 0 || out_valid[k]) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (q_size(k) != 0 || out_valid[k]) fail_now($sformatf("drain_timeout_cfg%0d", k));
  endtask

  typedef struct {
    logic [W-1:0]  av;
    logic [W-1:0]  bv;
    logic          c;
    logic          s;
    logic [EW-1:0] ev;
  } vec_t;

  // Expected field order: {ovf, cout, sum}.
  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}};
    vecs[4] = '{32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0008}};
    vecs[5] = '{32'h0000_000A, 32'h0000_000A, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0000}};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    rst = 1'b1;
    for (int k = 0; k < NCFG; k++) begin
      in_valid[k]  = 1'b0;
      a[k]         = '0;
      b[k]         = '0;
      cin[k]       = 1'b0;
      op_sub[k]    = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);

    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("reset_state_cfg%0d", k), dbg_state[k], IDLE);
      check($sformatf("reset_in_ready_cfg%0d", k), in_ready[k], 1);
      check($sformatf("reset_outputs_cfg%0d", k), {out_valid[k], ovf[k], cout[k], sum[k]}, '0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with latency check on every configuration.
    for (int k = 0; k < NCFG; k++) begin
      for (int v = 0; v < NVEC; v++) begin
        issue(k, vecs[v].av, vecs[v].bv, vecs[v].c, vecs[v].s, vecs[v].ev, 1'b1, acc);
        wait_valid(k);
        check($sformatf("latency_cfg%0d_v%0d", k, v), ncyc - acc, NCH[k] + 1);
        wait_idle(k);
      end
    end

    // Backpressure on the CHUNK=8 instance.
    out_ready[0] = 1'b0;
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345_678A}, 1'b1, acc);
    wait_valid(0);
    a[0] = 32'h0000_0001;
    b[0] = 32'h0000_0001;
    cin[0] = 1'b0;
    op_sub[0] = 1'b0;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid[0], 1);
      check("bp_in_ready", in_ready[0], 0);
      check("bp_hold", {ovf[0], cout[0], sum[0]}, {1'b0, 1'b0, 32'h2345_678A});
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    wait_idle(0);
    repeat (2) @(negedge clk);
    check("bp_no_extra_accept", dbg_state[0], IDLE);

    // Reset while RUN is at chunk index 2.
    issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '0, 1'b0, acc);
    repeat (2) @(negedge clk);
    check("mid_reset_in_run", dbg_state[0], RUN);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_state", dbg_state[0], IDLE);
    check("mid_reset_in_ready", in_ready[0], 1);
    check("mid_reset_outputs", {out_valid[0], sum[0]}, '0);
    issue(0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, {1'b0, 1'b0, 32'hDFAE_BFF0}, 1'b1, acc);
    wait_idle(0);

    // Back-to-back random ops; accepts must be NCHUNKS+2 cycles apart.
    for (int k = 0; k < NCFG; k++) begin
      prev = -1;
      for (int i = 0; i < 100; i++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        issue(k, ra, rb, rc, rs, ref_model(ra, rb, rc, rs), 1'b1, acc);
        if (prev >= 0 && i < 4) check($sformatf("spacing_cfg%0d", k), acc - prev, NCH[k] + 2);
        else if (prev >= 0 && acc - prev != NCH[k] + 2) check($sformatf("spacing_cfg%0d_op%0d", k, i), acc - prev, NCH[k] + 2);
        prev = acc;
      end
      wait_idle(k);
    end

    for (int k = 0; k < NCFG; k++) check($sformatf("queue_empty_cfg%0d", k), q_size(k), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
